// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch sequencer for the MIPS core. It holds the program counter,
// issues one instruction-memory read at a time over a req/ready handshake,
// presents each fetched word to decode over a valid/stall handshake, and
// computes the next fetch address from the decoded control-flow result.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a JR/JALR to a misaligned register target halts the
//   sequencer and raises the sticky AddrError flag. When undefined, the low two
//   bits of RegTarget are forced to zero, there is no HALT state and the
//   AddrError port does not exist.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Rst_n       in   asynchronous active-low reset
//   IMemReq     out  read request to instruction memory
//   IMemAddr    out  [31:0] word-aligned read address
//   IMemReady   in   memory returns data this cycle
//   IMemData    in   [31:0] read data, valid with IMemReady
//   InstrValid  out  Instr/InstrPC hold a fetched instruction
//   Instr       out  [31:0] fetched instruction word
//   InstrPC     out  [31:0] address of Instr
//   Stall       in   decode cannot accept; Instr is held
//   BranchTaken in   issued instruction is a taken branch
//   BranchImm   in   [15:0] raw branch immediate
//   Jump        in   issued instruction is J/JAL
//   JumpIndex   in   [25:0] raw jump index field
//   JumpReg     in   issued instruction is JR/JALR
//   RegTarget   in   [31:0] register jump target
//   AddrError   out  sticky misaligned-target flag (FETCH_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchImm,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        AddrError
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic [31:0] p4;
  logic [31:0] branch_off;
  logic [31:0] jr_target;
  logic [31:0] next_pc;
  logic        accept;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_error_q, addr_error_d;
  logic        jr_misaligned;
`endif

  // Control-flow target generation, all relative to the issued instruction.
  assign p4         = instr_pc_q + 32'd4;
  assign branch_off = {{14{BranchImm[15]}}, BranchImm, 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign jr_target     = RegTarget;
  assign jr_misaligned = JumpReg && (RegTarget[1:0] != 2'b00);
`else
  // Without the check a misaligned register target is silently word-aligned.
  assign jr_target = RegTarget & 32'hFFFF_FFFC;
`endif

  // Priority: JumpReg > Jump > BranchTaken > sequential.
  always_comb begin
    next_pc = p4;
    if (JumpReg) begin
      next_pc = jr_target;
    end else if (Jump) begin
      next_pc = {p4[31:28], JumpIndex, 2'b00};
    end else if (BranchTaken) begin
      next_pc = p4 + branch_off;
    end
  end

  // Redirect inputs matter only in this cycle.
  assign accept = (state_q == S_ISSUE) && !Stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    addr_error_d = addr_error_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMemReady) begin
          instr_d    = IMemData;
          instr_pc_d = pc_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (jr_misaligned) begin
            addr_error_d = 1'b1;
            state_d      = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc;
          state_d = S_FETCH;
`endif
        end
      end
      default: begin
        // S_HALT (when present) is only left through reset.
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_error_q <= 1'b0;
    end else begin
      addr_error_q <= addr_error_d;
    end
  end

  assign AddrError = addr_error_q;
`endif

  // The PC only changes on accept, so the address is stable for the whole
  // request, however many wait cycles memory inserts.
  assign IMemAddr   = pc_q;
  assign IMemReq    = (state_q == S_FETCH);
  assign InstrValid = (state_q == S_ISSUE);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed self-checking bench for fetch_sequencer with RESET_PC=0x0040_0000.
// Inputs are driven and outputs sampled on the falling clock edge. Honours
// FETCH_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchImm;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] RegTarget;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        AddrError;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_data;
  logic [31:0] last_addr;

  fetch_sequencer #(.RESET_PC(32'h0040_0000)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .Stall      (Stall),
    .BranchTaken(BranchTaken),
    .BranchImm  (BranchImm),
    .Jump       (Jump),
    .JumpIndex  (JumpIndex),
    .JumpReg    (JumpReg),
    .RegTarget  (RegTarget)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .AddrError  (AddrError)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_redirects();
    BranchTaken = 1'b0;
    BranchImm   = 16'h0;
    Jump        = 1'b0;
    JumpIndex   = 26'h0;
    JumpReg     = 1'b0;
    RegTarget   = 32'h0;
  endtask

  // Called at a falling edge while in FETCH; returns at a falling edge in ISSUE.
  task automatic fetch_one(input int waits, input logic [31:0] data, input logic [31:0] addr);
    check("fetch_valid_low", {31'b0, InstrValid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      IMemReady = 1'b0;
      IMemData  = 32'hBAD0_0000 | w;
      check("wait_req", {31'b0, IMemReq}, 32'd1);
      check("wait_addr", IMemAddr, addr);
      @(negedge Clk);
    end
    IMemReady = 1'b1;
    IMemData  = data;
    check("fetch_req", {31'b0, IMemReq}, 32'd1);
    check("fetch_addr", IMemAddr, addr);
    @(negedge Clk);
    IMemReady = 1'b0;
    IMemData  = 32'hDEAD_BEEF;
    check("issue_valid", {31'b0, InstrValid}, 32'd1);
    check("issue_req_low", {31'b0, IMemReq}, 32'd0);
    check("issue_instr", Instr, data);
    check("issue_pc", InstrPC, addr);
    last_data = data;
    last_addr = addr;
    $display("fetch addr=%h waits=%0d instr=%h", addr, waits, Instr);
  endtask

  // Holds Stall for 'stalls' cycles with junk redirects, then accepts.
  task automatic accept(input int stalls, input logic br, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx,
                        input logic jr, input logic [31:0] tgt);
    for (int s = 0; s < stalls; s++) begin
      Stall       = 1'b1;
      BranchTaken = s[0];
      Jump        = ~s[0];
      JumpReg     = s[1];
      RegTarget   = 32'h3333_3333;
      BranchImm   = 16'h0040;
      JumpIndex   = 26'h3FF_FFFF;
      @(negedge Clk);
      check("stall_valid", {31'b0, InstrValid}, 32'd1);
      check("stall_req_low", {31'b0, IMemReq}, 32'd0);
      check("stall_instr", Instr, last_data);
      check("stall_pc", InstrPC, last_addr);
    end
    Stall       = 1'b0;
    BranchTaken = br;
    BranchImm   = imm;
    Jump        = j;
    JumpIndex   = idx;
    JumpReg     = jr;
    RegTarget   = tgt;
    @(negedge Clk);
    clear_redirects();
    $display("accept pc=%h stalls=%0d br=%0b j=%0b jr=%0b", last_addr, stalls, br, j, jr);
  endtask

  initial begin
    Rst_n     = 1'b0;
    IMemReady = 1'b0;
    IMemData  = 32'h0;
    Stall     = 1'b0;
    clear_redirects();
    repeat (2) @(negedge Clk);

    check("rst_req", {31'b0, IMemReq}, 32'd0);
    check("rst_addr", IMemAddr, 32'h0040_0000);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc", InstrPC, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_addr_error", {31'b0, AddrError}, 32'd0);
`endif

    // Release; a ready pulse while still in IDLE must not be captured.
    Rst_n     = 1'b1;
    IMemReady = 1'b1;
    IMemData  = 32'h1111_1111;
    check("idle_req", {31'b0, IMemReq}, 32'd0);
    @(negedge Clk);
    IMemReady = 1'b0;

    // Zero-wait back-to-back sequential fetches.
    fetch_one(0, 32'hA000_0000, 32'h0040_0000);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch_one(0, 32'hA000_0001, 32'h0040_0004);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    // Three wait cycles, then JR to 0x100.
    fetch_one(3, 32'hA000_0002, 32'h0040_0008);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0100);
    // Stall 5 cycles with toggling redirects; branch -4 from 0x104 on accept.
    fetch_one(0, 32'hA000_0003, 32'h0000_0100);
    accept(5, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
    // JumpReg wins over Jump and BranchTaken.
    fetch_one(0, 32'hA000_0004, 32'h0000_0100);
    accept(0, 1'b1, 16'h0100, 1'b1, 26'h0000_777, 1'b1, 32'h0000_2000);
    fetch_one(0, 32'hA000_0005, 32'h0000_2000);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h9000_0000);
    // Jump keeps P4[31:28].
    fetch_one(0, 32'hA000_0006, 32'h9000_0000);
    accept(0, 1'b0, 16'h0, 1'b1, 26'h0000_010, 1'b0, 32'h0);
    fetch_one(0, 32'hA000_0007, 32'h9000_0040);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    // Sequential wrap past the top of the address space.
    fetch_one(0, 32'hA000_0008, 32'hFFFF_FFFC);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch_one(0, 32'hA000_0009, 32'h0000_0000);
    // Misaligned register target.
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2002);
`ifdef FETCH_ALIGN_CHECK_EN
    IMemReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("halt_req", {31'b0, IMemReq}, 32'd0);
      check("halt_valid", {31'b0, InstrValid}, 32'd0);
      check("halt_addr_error", {31'b0, AddrError}, 32'd1);
      @(negedge Clk);
    end
    IMemReady = 1'b0;
    $display("halt addr_error=%0b", AddrError);
    Rst_n = 1'b0;
    #1;
    check("halt_rst_addr_error", {31'b0, AddrError}, 32'd0);
    check("halt_rst_addr", IMemAddr, 32'h0040_0000);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    fetch_one(0, 32'hA000_000A, 32'h0040_0000);
`else
    fetch_one(0, 32'hA000_000A, 32'h0000_2000);
`endif

    // Reset in the middle of ISSUE drops InstrValid at once.
    Stall = 1'b1;
    #1;
    Rst_n = 1'b0;
    #1;
    check("abort_issue_valid", {31'b0, InstrValid}, 32'd0);
    check("abort_issue_instr", Instr, 32'h0);
    @(negedge Clk);
    Stall = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk);
    // Reset in the middle of FETCH (one wait cycle in) drops IMemReq at once.
    IMemReady = 1'b0;
    check("pre_abort_req", {31'b0, IMemReq}, 32'd1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("abort_fetch_req", {31'b0, IMemReq}, 32'd0);
    @(negedge Clk);
    // Late ready during IDLE is ignored.
    Rst_n     = 1'b1;
    IMemReady = 1'b1;
    IMemData  = 32'h5555_5555;
    @(negedge Clk);
    IMemReady = 1'b0;
    check("late_ready_valid", {31'b0, InstrValid}, 32'd0);
    fetch_one(1, 32'hA000_000B, 32'h0040_0000);
    accept(0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch_one(0, 32'hA000_000C, 32'h0040_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
